// File: rtl/trace_request_queue.sv
// trace_request_queue: samples L1/snoop trace buses, detects new commands and queues
// encoded {op, address} entries for the L2 controller through a valid/ready FIFO.
module trace_request_queue #(
  parameter int addressSize = 32,
  parameter int depth = 8,
  parameter int countWidth = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [addressSize-1:0]   L1BusIn,
  input  logic [15:0]              L1OperationBusIn,
  input  logic [addressSize-1:0]   sharedBusIn,
  input  logic [7:0]               sharedOperationBusIn,
  output logic                     reqValid,
  input  logic                     reqReady,
  output logic [3:0]               reqOp,
  output logic [addressSize-1:0]   reqAddress,
  output logic [$clog2(depth):0]   fifoCount,
  output logic [countWidth-1:0]    acceptedCount,
  output logic [15:0]              overflowCount,
  output logic [15:0]              collisionCount
);
  localparam int pw = $clog2(depth);
  logic [3:0] l1_d_op, sn_d_op, l1_op, sn_op, ev_op;
  logic l1_d_vld, sn_d_vld, l1_vld, sn_vld, l1_new, sn_new;
  logic [addressSize-1:0] l1_d_addr, sn_d_addr, l1_addr, sn_addr, ev_addr;
  logic [addressSize+3:0] mem [depth];
  logic [pw-1:0] wp, rp;
  logic ev, full, pop, push;
  always_comb begin
    l1_d_op = 4'd0;
    l1_d_vld = 1'b1;
    case (L1OperationBusIn)
      16'h4452: l1_d_op = 4'd0;
      16'h4457: l1_d_op = 4'd1;
      16'h4952: l1_d_op = 4'd2;
      16'h5053: l1_d_op = 4'd9;
      default:  l1_d_vld = 1'b0;
    endcase
  end
  always_comb begin
    sn_d_op = 4'd0;
    sn_d_vld = 1'b1;
    case (sharedOperationBusIn)
      8'h49:   sn_d_op = 4'd3;
      8'h52:   sn_d_op = 4'd4;
      8'h57:   sn_d_op = 4'd5;
      8'h4D:   sn_d_op = 4'd6;
      8'h4C:   sn_d_op = 4'd8;
      default: sn_d_vld = 1'b0;
    endcase
  end
  // clear and print carry no address, so a zero address keeps repeat detection honest
  assign l1_d_addr = (l1_d_op == 4'd9) ? '0 : L1BusIn;
  assign sn_d_addr = (sn_d_op == 4'd8) ? '0 : sharedBusIn;
  assign ev = l1_new | sn_new;
  assign ev_op = sn_new ? sn_op : l1_op;
  assign ev_addr = sn_new ? sn_addr : l1_addr;
  assign full = fifoCount == (pw+1)'(depth);
  assign reqValid = fifoCount != '0;
  assign pop = reqValid && reqReady;
  assign push = ev && (!full || pop);
  assign reqOp = reqValid ? mem[rp][addressSize+3:addressSize] : '0;
  assign reqAddress = reqValid ? mem[rp][addressSize-1:0] : '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l1_vld <= 1'b0;
      l1_op <= '0;
      l1_addr <= '0;
      l1_new <= 1'b0;
      sn_vld <= 1'b0;
      sn_op <= '0;
      sn_addr <= '0;
      sn_new <= 1'b0;
    end else begin
      l1_vld <= l1_d_vld;
      l1_op <= l1_d_op;
      l1_addr <= l1_d_addr;
      l1_new <= l1_d_vld && (!l1_vld || {l1_d_op, l1_d_addr} != {l1_op, l1_addr});
      sn_vld <= sn_d_vld;
      sn_op <= sn_d_op;
      sn_addr <= sn_d_addr;
      sn_new <= sn_d_vld && (!sn_vld || {sn_d_op, sn_d_addr} != {sn_op, sn_addr});
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      fifoCount <= '0;
      acceptedCount <= '0;
      overflowCount <= '0;
      collisionCount <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      fifoCount <= fifoCount + (pw+1)'(push) - (pw+1)'(pop);
      acceptedCount <= acceptedCount + countWidth'(push);
      overflowCount <= (ev && full && !pop && overflowCount != 16'hFFFF) ? overflowCount + 16'd1 : overflowCount;
      collisionCount <= (l1_new && sn_new && collisionCount != 16'hFFFF) ? collisionCount + 16'd1 : collisionCount;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {ev_op, ev_addr};
  end
endmodule

// File: doc/trace_request_queue.md
# trace_request_queue

Registered front end between the trace-file bus driver and the L2 cache controller. Samples the L1 and snoop command/address buses every clock, detects each new trace command, encodes it into a 4-bit opcode, and buffers it in a FIFO. The cache controller pops commands through a valid/ready handshake. Dropped and accepted commands are counted for end-of-run statistics.

## Interface
- `addressSize`, 32, width of the address buses and the queued address.
- `depth`, 8, FIFO entries; power of two, ≥2.
- `countWidth`, 32, width of `acceptedCount`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `L1BusIn`  in  addressSize  L1 request address.
- `L1OperationBusIn`  in  16  ASCII L1 op: "DR", "DW", "IR", "PS".
- `sharedBusIn`  in  addressSize  snooped address.
- `sharedOperationBusIn`  in  8  ASCII snoop op: 'I', 'R', 'W', 'M', 'L' (clear).
- `reqValid`  out  1  head entry valid.
- `reqReady`  in  1  controller accepts head.
- `reqOp`  out  4  head opcode.
- `reqAddress`  out  addressSize  head address.
- `fifoCount`  out  $clog2(depth)+1  occupancy.
- `acceptedCount`  out  countWidth  commands enqueued; wraps.
- `overflowCount`  out  16  commands dropped because FIFO full; saturates at 0xFFFF.
- `collisionCount`  out  16  L1 commands dropped on same-cycle collision; saturates.

## Operation
- Opcodes: "DR"→0, "DW"→1, "IR"→2, 'I'→3, 'R'→4, 'W'→5, 'M'→6, 'L'→8, "PS"→9. Snoop ops take `sharedBusIn`. L1 ops take `L1BusIn`. For 8 and 9 the stored address is 0.
- Decoding uses exact 0/1 matching. Any X/Z bit, or any other code, means idle for that bus.
- Stage 1 sample registers hold per bus: decoded op, op-valid, and address.
- New event on a bus: sampled op-valid is 1, AND either the previous sample was idle or the {op, address} pair differs from the previous sample.
- A command held for many cycles is therefore captured once. Identical commands separated by an idle (Z) gap are captured separately.
- If both buses have a new event in the same cycle, the snoop event is enqueued, the L1 event is dropped, and `collisionCount` increments.
- Stage 2 FIFO push: push when a new event exists and the FIFO is not full.
  - If the FIFO is full and no pop occurs that cycle, the event is dropped and `overflowCount` increments.
  - Existing entries are never overwritten.
- Pop: `reqValid && reqReady` at an edge removes the head.
- Push and pop in the same cycle while full: both occur and `fifoCount` is unchanged.
- Clear (8) and print (9) are ordinary queued commands, ordered with all other commands. The queue does not flush itself.
- `acceptedCount` increments on every successful push.

## Timing
- Reset (asynchronous assert) sets the following to 0 immediately: sample registers (idle), FIFO pointers, `fifoCount`, `reqValid`, `reqOp`, `reqAddress`, and all counters.
- Reset release is synchronous to the next `clk` edge. A command held on a bus through reset release is captured exactly once, at the first edge after release.
- Latency: bus stable before edge k, sampled at k, pushed at k+1. `reqValid` is high in the cycle after edge k+1, so 2 edges minimum.
- Empty FIFO: no bypass. A push and a pop cannot involve the same entry in one cycle.
- Handshake: `reqOp` and `reqAddress` stay stable while `reqValid && !reqReady`. `reqValid` never drops without a pop, except on reset.
- Pointers wrap modulo `depth`. Full when `fifoCount == depth`, empty when 0.
- Reset asserted mid-handshake discards all queued entries.

## Test plan
- L1 "DR" addr 0x0000_1234 held 5 cycles, then Z, `reqReady=1` → exactly one entry with op 0, addr 0x1234, `reqValid` 2 edges after first sample; `acceptedCount=1`.
- Snoop 'M' 0xDEAD_BEE0, then Z, then 'M' 0xDEAD_BEE0 again → two op-6 entries.
- `reqReady=0`, 10 distinct L1 "DW" commands, depth 8 → `fifoCount=8`, `overflowCount=2`. Then drain → the first 8 addresses pop in order.
- Same cycle: L1 "IR" 0x40 and snoop 'R' 0x80 → only op 4 addr 0x80 queued; `collisionCount=1`.
- Full FIFO with `reqReady=1` and a new event on the same edge → push accepted, `fifoCount` stays 8, `overflowCount` unchanged.
- 3 entries queued, `reset_n` pulsed low mid-cycle → outputs 0 immediately. A "PS" held across reset release is queued once as op 9, addr 0.
